// File: rtl/ish_adder_pkg.sv
// Shared definitions for the registered accumulate/add block.
// Holds the op encodings and the output-register state type.
package ish_adder_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/ish_addsub_core.sv
// Combinational add/subtract with carry/borrow, signed overflow and optional unsigned clamp.
// carry/overflow always describe the raw operation, even when the sum is clamped.
module ish_addsub_core
    import ish_adder_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    op_e              w_op;
    logic [WIDTH:0]   w_raw;

    assign w_op = op_e'(op);

    always_comb begin
        w_raw    = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (w_op)
            OP_ADD, OP_ACC: begin
                w_raw    = {1'b0, x} + {1'b0, y};
                carry    = w_raw[WIDTH];
                overflow = (x[WIDTH-1] == y[WIDTH-1]) && (w_raw[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra MSB of the widened difference is the borrow (x < y).
                w_raw    = {1'b0, x} - {1'b0, y};
                carry    = w_raw[WIDTH];
                overflow = (x[WIDTH-1] != y[WIDTH-1]) && (w_raw[WIDTH-1] != x[WIDTH-1]);
            end
            default: begin
                w_raw    = '0;
                carry    = 1'b0;
                overflow = 1'b0;
            end
        endcase

        sum = w_raw[WIDTH-1:0];
        if ((SATURATE != 0) && carry) begin
            sum = (w_op == OP_SUB) ? '0 : '1;
        end
    end

endmodule

// File: rtl/ish_accum_adder.sv
// Registered add/sub/accumulate/clear unit with valid/ready handshakes.
// Keeps a running accumulator and sticky carry/overflow flags fed by ACC ops.
module ish_accum_adder
    import ish_adder_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic [WIDTH-1:0] acc,
    output logic             sticky_carry,
    output logic             sticky_ovf
);

    out_state_e       r_state;
    out_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_ovf;
    logic [WIDTH-1:0] r_acc;
    logic             r_sticky_c;
    logic             r_sticky_v;

    logic             w_accept;
    op_e              w_op;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_ovf;

    assign w_op     = op_e'(op);
    assign in_ready = (r_state == ST_EMPTY) || out_ready;
    assign w_accept = in_valid && in_ready;

    // ACC adds operand A onto the accumulator; everything else works on A/B.
    assign w_x = (w_op == OP_ACC) ? r_acc : a;

    ish_addsub_core #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_core (
        .x        (w_x),
        .y        ((w_op == OP_ACC) ? a : b),
        .op       (op),
        .sum      (w_sum),
        .carry    (w_carry),
        .overflow (w_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = ST_FULL;
        end else if (out_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_acc      <= '0;
            r_sticky_c <= 1'b0;
            r_sticky_v <= 1'b0;
        end else if (w_accept) begin
            r_result <= w_sum;
            r_carry  <= w_carry;
            r_ovf    <= w_ovf;
            case (w_op)
                OP_ACC: begin
                    r_acc      <= w_sum;
                    r_sticky_c <= r_sticky_c | w_carry;
                    r_sticky_v <= r_sticky_v | w_ovf;
                end
                OP_CLR: begin
                    r_acc      <= '0;
                    r_sticky_c <= 1'b0;
                    r_sticky_v <= 1'b0;
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    assign out_valid    = (r_state == ST_FULL);
    assign result       = r_result;
    assign carry        = r_carry;
    assign overflow     = r_ovf;
    assign acc          = r_acc;
    assign sticky_carry = r_sticky_c;
    assign sticky_ovf   = r_sticky_v;

endmodule

// File: tb/tb_ish_accum_adder.sv
// Bench for ish_accum_adder: wrap and saturating instances share one stimulus stream
// and are compared each cycle against an integer-arithmetic reference model.
module tb_ish_accum_adder;

    localparam logic [1:0] T_ADD = 2'b00;
    localparam logic [1:0] T_SUB = 2'b01;
    localparam logic [1:0] T_ACC = 2'b10;
    localparam logic [1:0] T_CLR = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [1:0] op = '0;

    logic       in_ready  [2];
    logic       out_valid [2];
    logic [7:0] result    [2];
    logic       carry     [2];
    logic       overflow  [2];
    logic [7:0] acc       [2];
    logic       sticky_c  [2];
    logic       sticky_v  [2];

    int n_checks = 0;
    int n_errors = 0;

    logic       m_valid;
    logic [7:0] m_res [2];
    logic       m_c   [2];
    logic       m_v   [2];
    logic [7:0] m_acc [2];
    logic       m_sc  [2];
    logic       m_sv  [2];

    always #5 clk = ~clk;

    ish_accum_adder #(.WIDTH(8), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a(a), .b(b), .op(op), .out_valid(out_valid[0]), .out_ready(out_ready),
        .result(result[0]), .carry(carry[0]), .overflow(overflow[0]), .acc(acc[0]),
        .sticky_carry(sticky_c[0]), .sticky_ovf(sticky_v[0])
    );

    ish_accum_adder #(.WIDTH(8), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a(a), .b(b), .op(op), .out_valid(out_valid[1]), .out_ready(out_ready),
        .result(result[1]), .carry(carry[1]), .overflow(overflow[1]), .acc(acc[1]),
        .sticky_carry(sticky_c[1]), .sticky_ovf(sticky_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on plain integers: range tests instead of bit tricks.
    function automatic void model_op(input bit sat, input logic [1:0] o,
                                     input logic [7:0] x, input logic [7:0] y,
                                     output logic [7:0] r, output logic c, output logic v);
        int ux = int'(x);
        int uy = int'(y);
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        int raw;
        int sraw;
        r = 8'h00; c = 1'b0; v = 1'b0;
        if (o == T_ADD || o == T_ACC) begin
            raw  = ux + uy;
            sraw = sx + sy;
            c    = (raw > 255);
            v    = (sraw > 127) || (sraw < -128);
            r    = (sat && c) ? 8'hFF : 8'(raw);
        end else if (o == T_SUB) begin
            raw  = ux - uy;
            sraw = sx - sy;
            c    = (ux < uy);
            v    = (sraw > 127) || (sraw < -128);
            r    = (sat && c) ? 8'h00 : 8'(raw);
        end
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        for (int s = 0; s < 2; s++) begin
            m_res[s] = '0; m_c[s] = 0; m_v[s] = 0;
            m_acc[s] = '0; m_sc[s] = 0; m_sv[s] = 0;
        end
    endtask

    task automatic check_all(input string where);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("%s s%0d out_valid", where, s), 32'(out_valid[s]), 32'(m_valid));
            chk($sformatf("%s s%0d in_ready", where, s), 32'(in_ready[s]), 32'(!m_valid || out_ready));
            chk($sformatf("%s s%0d result", where, s), 32'(result[s]), 32'(m_res[s]));
            chk($sformatf("%s s%0d carry", where, s), 32'(carry[s]), 32'(m_c[s]));
            chk($sformatf("%s s%0d overflow", where, s), 32'(overflow[s]), 32'(m_v[s]));
            chk($sformatf("%s s%0d acc", where, s), 32'(acc[s]), 32'(m_acc[s]));
            chk($sformatf("%s s%0d sticky_carry", where, s), 32'(sticky_c[s]), 32'(m_sc[s]));
            chk($sformatf("%s s%0d sticky_ovf", where, s), 32'(sticky_v[s]), 32'(m_sv[s]));
        end
    endtask

    // One clock edge: advance the model with the inputs held across the edge, then compare.
    task automatic step(input string where);
        logic       take;
        logic [7:0] x;
        logic [7:0] y;
        @(posedge clk);
        take = in_valid && (!m_valid || out_ready);
        if (take) begin
            for (int s = 0; s < 2; s++) begin
                x = (op == T_ACC) ? m_acc[s] : a;
                y = (op == T_ACC) ? a : b;
                model_op(s == 1, op, x, y, m_res[s], m_c[s], m_v[s]);
                if (op == T_ACC) begin
                    m_acc[s] = m_res[s];
                    m_sc[s]  = m_sc[s] | m_c[s];
                    m_sv[s]  = m_sv[s] | m_v[s];
                end else if (op == T_CLR) begin
                    m_acc[s] = '0; m_sc[s] = 0; m_sv[s] = 0;
                end
            end
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check_all(where);
    endtask

    task automatic issue(input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb);
        in_valid = 1'b1; out_ready = 1'b1; op = o; a = va; b = vb;
        step("dir");
    endtask

    initial begin
        model_reset();
        a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
        in_valid = 1'($urandom); out_ready = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        for (int s = 0; s < 2; s++) chk("reset in_ready", 32'(in_ready[s]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        issue(T_ADD, 8'hF0, 8'h20);
        chk("add wrap result", 32'(result[0]), 32'h10);
        chk("add wrap carry", 32'(carry[0]), 32'd1);
        chk("add wrap ovf", 32'(overflow[0]), 32'd0);
        chk("add sat result", 32'(result[1]), 32'hFF);

        issue(T_ADD, 8'h7F, 8'h01);
        chk("add ovf result", 32'(result[0]), 32'h80);
        chk("add ovf carry", 32'(carry[0]), 32'd0);
        chk("add ovf flag", 32'(overflow[0]), 32'd1);

        issue(T_SUB, 8'h10, 8'h20);
        chk("sub wrap result", 32'(result[0]), 32'hF0);
        chk("sub wrap borrow", 32'(carry[0]), 32'd1);
        chk("sub sat result", 32'(result[1]), 32'h00);
        chk("sub sat borrow", 32'(carry[1]), 32'd1);

        issue(T_ACC, 8'h7F, 8'h00);
        chk("acc1 acc", 32'(acc[0]), 32'h7F);
        issue(T_ACC, 8'h01, 8'h00);
        chk("acc2 acc", 32'(acc[0]), 32'h80);
        chk("acc2 ovf", 32'(overflow[0]), 32'd1);
        chk("acc2 sticky_ovf", 32'(sticky_v[0]), 32'd1);
        issue(T_CLR, 8'hAA, 8'h55);
        chk("clr result", 32'(result[0]), 32'h00);
        chk("clr acc", 32'(acc[0]), 32'h00);
        chk("clr sticky_ovf", 32'(sticky_v[0]), 32'd0);

        issue(T_ADD, 8'h11, 8'h22);
        out_ready = 1'b0; op = T_ADD; a = 8'h01; b = 8'h02;
        #1;
        chk("bp in_ready low", 32'(in_ready[0]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step("bp");
            chk("bp result held", 32'(result[0]), 32'h33);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready[0]), 32'd1);
        step("bp_rel");
        chk("bp next result", 32'(result[0]), 32'h03);
        chk("bp next valid", 32'(out_valid[0]), 32'd1);

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op        = ($urandom_range(0, 15) == 0) ? T_CLR : 2'($urandom_range(0, 2));
            a         = 8'($urandom);
            b         = 8'($urandom);
            step("rand");
        end

        issue(T_CLR, 8'h00, 8'h00);
        issue(T_ACC, 8'h55, 8'h00);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pre-rst acc", 32'(acc[0]), 32'h55);
        chk("pre-rst valid", 32'(out_valid[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int s = 0; s < 2; s++) begin
            chk("midrst acc", 32'(acc[s]), 32'h00);
            chk("midrst valid", 32'(out_valid[s]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(T_ADD, 8'h01, 8'h01);
        chk("post-rst add", 32'(result[0]), 32'h02);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
